// File: rtl/prco_decode_pkg.sv
// ISA definitions shared by the prco decode/issue stage: field positions, opcodes, decoded control.
package prco_decode_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;
  localparam int REG_COUNT = 2 ** REG_SEL_W;
  localparam int OP_W      = 5;
  localparam int IMM_W     = 8;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 11;
  localparam int RD_MSB = 10;
  localparam int RD_LSB = 8;
  localparam int RA_MSB = 7;
  localparam int RA_LSB = 5;
  localparam int RB_MSB = 4;
  localparam int RB_LSB = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 5'h00,
    OP_ADD  = 5'h01,
    OP_SUB  = 5'h02,
    OP_AND  = 5'h03,
    OP_OR   = 5'h04,
    OP_MOVI = 5'h05,
    OP_LW   = 5'h06,
    OP_SW   = 5'h07,
    OP_HALT = 5'h1F
  } opcode_e;

  typedef struct packed {
    logic    uses_ra;
    logic    uses_rb;
    logic    writes;
    logic    use_imm;
    logic    mem_rd;
    logic    mem_wr;
    logic    halt;
    logic    illegal;
    opcode_e opcode;
  } ctrl_t;

  // Illegal opcodes decode to a NOP with only the illegal flag raised.
  function automatic ctrl_t decode_op(input logic [OP_W-1:0] op);
    ctrl_t c;
    c        = '0;
    c.opcode = OP_NOP;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        c.opcode  = opcode_e'(op);
        c.uses_ra = 1'b1;
        c.uses_rb = 1'b1;
        c.writes  = 1'b1;
      end
      OP_MOVI: begin
        c.opcode  = OP_MOVI;
        c.writes  = 1'b1;
        c.use_imm = 1'b1;
      end
      OP_LW: begin
        c.opcode  = OP_LW;
        c.uses_ra = 1'b1;
        c.writes  = 1'b1;
        c.mem_rd  = 1'b1;
      end
      OP_SW: begin
        c.opcode  = OP_SW;
        c.uses_ra = 1'b1;
        c.uses_rb = 1'b1;
        c.mem_wr  = 1'b1;
      end
      OP_HALT: begin
        c.opcode = OP_HALT;
        c.halt   = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prco_scoreboard.sv
// Per-register busy tracking for outstanding writes, with hazard lookup against registered state.
module prco_scoreboard
  import prco_decode_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_set,
  input  logic [REG_SEL_W-1:0] i_set_sel,
  input  logic                 i_clr,
  input  logic [REG_SEL_W-1:0] i_clr_sel,
  input  logic                 i_uses_ra,
  input  logic [REG_SEL_W-1:0] i_ra,
  input  logic                 i_uses_rb,
  input  logic [REG_SEL_W-1:0] i_rb,
  input  logic                 i_writes,
  input  logic [REG_SEL_W-1:0] i_rd,
  output logic                 q_hazard
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (i_set) set_mask[i_set_sel] = 1'b1;
    if (i_clr) clr_mask[i_clr_sel] = 1'b1;
  end

  // Set is applied after clear so a new issue wins over a same-cycle writeback.
  always_ff @(posedge i_clk) begin
    if (i_reset) busy <= '0;
    else         busy <= (busy & ~clr_mask) | set_mask;
  end

  assign q_hazard = (i_uses_ra & busy[i_ra]) |
                    (i_uses_rb & busy[i_rb]) |
                    (i_writes  & busy[i_rd]);

endmodule

// File: rtl/prco_decode.sv
// Decode/issue stage: drives register-file read selects, registers decoded control, stalls on hazards.
module prco_decode
  import prco_decode_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [DATA_W-1:0]    i_inst,
  input  logic                 i_inst_valid,
  output logic                 q_inst_ready,
  output logic [REG_SEL_W-1:0] q_sela,
  output logic [REG_SEL_W-1:0] q_selb,
  output logic                 q_valid,
  input  logic                 i_ready,
  output logic [OP_W-1:0]      q_opcode,
  output logic [REG_SEL_W-1:0] q_seld,
  output logic                 q_we,
  output logic [DATA_W-1:0]    q_imm,
  output logic                 q_use_imm,
  output logic                 q_mem_rd,
  output logic                 q_mem_wr,
  output logic                 q_halted,
  output logic                 q_illegal,
  input  logic                 i_wb_we,
  input  logic [REG_SEL_W-1:0] i_wb_seld
);

  ctrl_t                ctrl;
  logic [REG_SEL_W-1:0] rd;
  logic                 hazard;
  logic                 accept;

  assign ctrl   = decode_op(i_inst[OP_MSB:OP_LSB]);
  assign rd     = i_inst[RD_MSB:RD_LSB];
  assign q_sela = i_inst[RA_MSB:RA_LSB];
  assign q_selb = i_inst[RB_MSB:RB_LSB];

  assign q_inst_ready = i_en & ~q_halted & ~hazard & (~q_valid | i_ready);
  assign accept       = i_inst_valid & q_inst_ready;

  prco_scoreboard u_scoreboard (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_set     (accept & ctrl.writes),
    .i_set_sel (rd),
    .i_clr     (i_wb_we),
    .i_clr_sel (i_wb_seld),
    .i_uses_ra (ctrl.uses_ra),
    .i_ra      (q_sela),
    .i_uses_rb (ctrl.uses_rb),
    .i_rb      (q_selb),
    .i_writes  (ctrl.writes),
    .i_rd      (rd),
    .q_hazard  (hazard)
  );

  // q_illegal is recomputed every cycle so it stays a single-cycle pulse even if i_en drops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      q_valid   <= 1'b0;
      q_opcode  <= '0;
      q_seld    <= '0;
      q_we      <= 1'b0;
      q_imm     <= '0;
      q_use_imm <= 1'b0;
      q_mem_rd  <= 1'b0;
      q_mem_wr  <= 1'b0;
      q_halted  <= 1'b0;
      q_illegal <= 1'b0;
    end else begin
      if (accept) begin
        q_valid   <= 1'b1;
        q_opcode  <= ctrl.opcode;
        q_seld    <= rd;
        q_we      <= ctrl.writes;
        q_imm     <= {{(DATA_W-IMM_W){1'b0}}, i_inst[IMM_W-1:0]};
        q_use_imm <= ctrl.use_imm;
        q_mem_rd  <= ctrl.mem_rd;
        q_mem_wr  <= ctrl.mem_wr;
      end else if (i_en && q_valid && i_ready) begin
        q_valid <= 1'b0;
      end
      if (accept && ctrl.halt) q_halted <= 1'b1;
      q_illegal <= accept & ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_prco_decode.sv
// Directed self-checking bench for prco_decode with hand-computed expected values.
module tb_prco_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] inst;
  logic        instValid;
  logic        instReady;
  logic [2:0]  selA;
  logic [2:0]  selB;
  logic        valid;
  logic        ready;
  logic [4:0]  opcode;
  logic [2:0]  selD;
  logic        we;
  logic [15:0] imm;
  logic        useImm;
  logic        memRd;
  logic        memWr;
  logic        halted;
  logic        illegal;
  logic        wbWe;
  logic [2:0]  wbSel;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  prco_decode dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (en),
    .i_inst       (inst),
    .i_inst_valid (instValid),
    .q_inst_ready (instReady),
    .q_sela       (selA),
    .q_selb       (selB),
    .q_valid      (valid),
    .i_ready      (ready),
    .q_opcode     (opcode),
    .q_seld       (selD),
    .q_we         (we),
    .q_imm        (imm),
    .q_use_imm    (useImm),
    .q_mem_rd     (memRd),
    .q_mem_wr     (memWr),
    .q_halted     (halted),
    .q_illegal    (illegal),
    .i_wb_we      (wbWe),
    .i_wb_seld    (wbSel)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] i, input logic v, input logic r,
                               input logic w, input logic [2:0] s);
    inst      = i;
    instValid = v;
    ready     = r;
    wbWe      = w;
    wbSel     = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    tick();
    checkOutput("init_valid", {31'b0, valid}, 32'd0);
    checkOutput("init_busy", {24'b0, dut.u_scoreboard.busy}, 32'h00);
    reset = 1'b0;
    #1;
    checkOutput("init_ready", {31'b0, instReady}, 32'd1);

    // MOVI r1,#F0 then dependent ADD r2,r1,r1
    applyStimulus(16'h29F0, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("movi_valid", {31'b0, valid}, 32'd1);
    checkOutput("movi_op", {27'b0, opcode}, 32'h05);
    checkOutput("movi_seld", {29'b0, selD}, 32'd1);
    checkOutput("movi_we", {31'b0, we}, 32'd1);
    checkOutput("movi_imm", {16'b0, imm}, 32'h00F0);
    checkOutput("movi_useimm", {31'b0, useImm}, 32'd1);
    checkOutput("movi_busy", {24'b0, dut.u_scoreboard.busy}, 32'h02);
    applyStimulus(16'h0A24, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("add_sela", {29'b0, selA}, 32'd1);
    checkOutput("add_selb", {29'b0, selB}, 32'd1);
    checkOutput("add_stall", {31'b0, instReady}, 32'd0);
    tick();
    checkOutput("add_drain", {31'b0, valid}, 32'd0);
    applyStimulus(16'h0A24, 1'b1, 1'b1, 1'b1, 3'd1);
    #1;
    checkOutput("add_wb_nobypass", {31'b0, instReady}, 32'd0);
    tick();
    applyStimulus(16'h0A24, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("add_ready_after_wb", {31'b0, instReady}, 32'd1);
    tick();
    checkOutput("add_valid", {31'b0, valid}, 32'd1);
    checkOutput("add_op", {27'b0, opcode}, 32'h01);
    checkOutput("add_seld", {29'b0, selD}, 32'd2);
    checkOutput("add_useimm", {31'b0, useImm}, 32'd0);

    // Back-to-back independent ADDs: r3, r5, r6
    applyStimulus(16'h0B94, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("b2b_ready0", {31'b0, instReady}, 32'd1);
    tick();
    checkOutput("b2b_seld0", {29'b0, selD}, 32'd3);
    applyStimulus(16'h0DDC, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("b2b_ready1", {31'b0, instReady}, 32'd1);
    tick();
    checkOutput("b2b_seld1", {29'b0, selD}, 32'd5);
    applyStimulus(16'h0E00, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("b2b_seld2", {29'b0, selD}, 32'd6);
    checkOutput("b2b_valid", {31'b0, valid}, 32'd1);
    checkOutput("b2b_busy", {24'b0, dut.u_scoreboard.busy}, 32'h6C);
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 3'd2);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 3'd3);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 3'd5);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 3'd6);
    tick();
    checkOutput("wb_clear_busy", {24'b0, dut.u_scoreboard.busy}, 32'h00);
    checkOutput("idle_valid", {31'b0, valid}, 32'd0);

    // Downstream backpressure holds outputs
    applyStimulus(16'h2F5A, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    applyStimulus(16'h0824, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("bp_ready", {31'b0, instReady}, 32'd0);
      checkOutput("bp_valid", {31'b0, valid}, 32'd1);
      checkOutput("bp_seld", {29'b0, selD}, 32'd7);
      checkOutput("bp_imm", {16'b0, imm}, 32'h005A);
      tick();
    end
    applyStimulus(16'h0824, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("bp_release_ready", {31'b0, instReady}, 32'd1);
    tick();
    checkOutput("bp_next_seld", {29'b0, selD}, 32'd0);
    checkOutput("bp_next_op", {27'b0, opcode}, 32'h01);

    // Disabled stage: no accept/drain, writeback still clears busy
    en = 1'b0;
    applyStimulus(16'h0B94, 1'b1, 1'b1, 1'b1, 3'd7);
    #1;
    checkOutput("en0_ready", {31'b0, instReady}, 32'd0);
    tick();
    checkOutput("en0_hold_valid", {31'b0, valid}, 32'd1);
    checkOutput("en0_hold_seld", {29'b0, selD}, 32'd0);
    checkOutput("en0_wb_busy", {24'b0, dut.u_scoreboard.busy}, 32'h01);
    en = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 3'd0);
    tick();
    checkOutput("en1_drain", {31'b0, valid}, 32'd0);
    checkOutput("en1_busy", {24'b0, dut.u_scoreboard.busy}, 32'h00);

    // Same-cycle set/clear on r3, then dependent SW and an LW
    applyStimulus(16'h2B11, 1'b1, 1'b1, 1'b1, 3'd3);
    tick();
    checkOutput("setwins_busy", {24'b0, dut.u_scoreboard.busy}, 32'h08);
    applyStimulus(16'h3870, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("sw_stall", {31'b0, instReady}, 32'd0);
    tick();
    applyStimulus(16'h3870, 1'b1, 1'b1, 1'b1, 3'd3);
    tick();
    applyStimulus(16'h3870, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("sw_ready", {31'b0, instReady}, 32'd1);
    tick();
    checkOutput("sw_memwr", {31'b0, memWr}, 32'd1);
    checkOutput("sw_we", {31'b0, we}, 32'd0);
    checkOutput("sw_busy", {24'b0, dut.u_scoreboard.busy}, 32'h00);
    applyStimulus(16'h3400, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("lw_memrd", {31'b0, memRd}, 32'd1);
    checkOutput("lw_memwr", {31'b0, memWr}, 32'd0);
    checkOutput("lw_seld", {29'b0, selD}, 32'd4);
    checkOutput("lw_busy", {24'b0, dut.u_scoreboard.busy}, 32'h10);
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b1, 3'd4);
    tick();

    // Illegal opcode then HALT
    applyStimulus(16'h8000, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("ill_pulse", {31'b0, illegal}, 32'd1);
    checkOutput("ill_we", {31'b0, we}, 32'd0);
    checkOutput("ill_op", {27'b0, opcode}, 32'h00);
    checkOutput("ill_valid", {31'b0, valid}, 32'd1);
    applyStimulus(16'hF800, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("ill_cleared", {31'b0, illegal}, 32'd0);
    checkOutput("halt_flag", {31'b0, halted}, 32'd1);
    checkOutput("halt_op", {27'b0, opcode}, 32'h1F);
    checkOutput("halt_ready", {31'b0, instReady}, 32'd0);
    applyStimulus(16'h0E00, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    checkOutput("halt_drain", {31'b0, valid}, 32'd0);
    checkOutput("halt_sticky", {31'b0, halted}, 32'd1);
    checkOutput("halt_noaccept", {24'b0, dut.u_scoreboard.busy}, 32'h00);

    // Reset clears halt; fill the scoreboard then reset mid-stall
    reset = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_halted", {31'b0, halted}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      applyStimulus({5'h05, r[2:0], 8'h00}, 1'b1, 1'b1, 1'b0, 3'd0);
      tick();
    end
    checkOutput("fill_busy", {24'b0, dut.u_scoreboard.busy}, 32'hFF);
    checkOutput("fill_valid", {31'b0, valid}, 32'd1);
    applyStimulus(16'h0A24, 1'b1, 1'b0, 1'b1, 3'd2);
    reset = 1'b1;
    tick();
    checkOutput("midrst_busy", {24'b0, dut.u_scoreboard.busy}, 32'h00);
    checkOutput("midrst_valid", {31'b0, valid}, 32'd0);
    checkOutput("midrst_seld", {29'b0, selD}, 32'd0);
    reset = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("midrst_ready", {31'b0, instReady}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
